// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester handshakes (core on port 0, host loader/DMA on
// port 1), the grant vector and the unified memory bus into one interface.
//
//   c<n>_req/we/addr/wdata : requester -> arbiter, held stable until c<n>_ready
//   c<n>_ready/rdata       : arbiter -> requester, ready is a 1-cycle pulse
//   gnt                    : one-hot owner of the memory (00 when idle)
//   mem_we/mem_a/mem_wd    : arbiter -> memory (synchronous write)
//   mem_rd                 : memory -> arbiter (combinational read of mem_a)
//
// Modports:
//   master : requesters plus memory model (the environment around the arbiter)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              c0_req;
    logic              c0_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_ready;
    logic [DATA_W-1:0] c0_rdata;

    logic              c1_req;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_ready;
    logic [DATA_W-1:0] c1_rdata;

    logic [1:0]        gnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        output mem_rd,
        input  c0_ready, c0_rdata, c1_ready, c1_rdata,
        input  gnt, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        input  mem_rd,
        output c0_ready, c0_rdata, c1_ready, c1_rdata,
        output gnt, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the unified instruction/data memory between the multicycle core
// (port 0) and the host loader/DMA (port 1). One transaction at a time:
// IDLE picks an owner, ACCESS drives the memory for 1 + WAIT_STATES cycles,
// RESP pulses the owner's ready with the registered read data.
//
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave (requester handshakes, gnt, memory bus)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending requests
// ACCESS| owner's addr/wdata on the memory bus; write strobe on last cycle
// RESP  | owner's ready pulses with the captured read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_gnt;
    logic              r_c0_ready;
    logic              r_c1_ready;

    logic              w_pick1;
    logic              w_in_access;
    logic              w_owner_we;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [DATA_W-1:0] w_owner_wdata;

    // Port 1 wins when it is the only requester, or on a tie when round-robin
    // is active and port 0 was served last.
    assign w_pick1 = bus.c1_req &&
                     (!bus.c0_req || ((FIXED_PRIO == 0) && !r_last));

    // Owner's request fields are used live, not latched: the requester is
    // required to hold them stable until it sees ready.
    assign w_owner_we    = r_owner ? bus.c1_we    : bus.c0_we;
    assign w_owner_addr  = r_owner ? bus.c1_addr  : bus.c0_addr;
    assign w_owner_wdata = r_owner ? bus.c1_wdata : bus.c0_wdata;

    assign w_in_access = (r_state == ST_ACCESS);

    assign bus.mem_a  = w_in_access ? w_owner_addr  : '0;
    assign bus.mem_wd = w_in_access ? w_owner_wdata : '0;
    // Write strobe only on the final ACCESS cycle so a reset during the wait
    // states leaves memory untouched.
    assign bus.mem_we = w_in_access && (r_cnt == 4'd0) && w_owner_we;

    assign bus.gnt      = r_gnt;
    assign bus.c0_ready = r_c0_ready;
    assign bus.c1_ready = r_c1_ready;
    assign bus.c0_rdata = r_rdata;
    assign bus.c1_rdata = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_cnt      <= 4'd0;
            r_rdata    <= '0;
            r_gnt      <= 2'b00;
            r_c0_ready <= 1'b0;
            r_c1_ready <= 1'b0;
        end else begin
            r_c0_ready <= 1'b0;
            r_c1_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.c0_req || bus.c1_req) begin
                        r_owner <= w_pick1;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Captured on writes too so rdata never holds stale X.
                        r_rdata <= bus.mem_rd;
                        if (r_owner) begin
                            r_c1_ready <= 1'b1;
                        end else begin
                            r_c0_ready <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_owner;
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiter instances share one clock and reset:
//   u0 : WAIT_STATES=0, round-robin
//   u1 : WAIT_STATES=0, fixed priority
//   u3 : WAIT_STATES=3, round-robin
// Each has its own 64-word memory model (combinational read, synchronous write).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0), .FIXED_PRIO(0))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0), .FIXED_PRIO(1))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(3), .FIXED_PRIO(0))
        u3 (.clk(clk), .reset(reset), .bus(if3));

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    assign if0.mem_rd = mem0[if0.mem_a[7:2]];
    assign if1.mem_rd = mem1[if1.mem_a[7:2]];
    assign if3.mem_rd = mem3[if3.mem_a[7:2]];

    always @(posedge clk) begin
        if (if0.mem_we) mem0[if0.mem_a[7:2]] <= if0.mem_wd;
        if (if1.mem_we) mem1[if1.mem_a[7:2]] <= if1.mem_wd;
        if (if3.mem_we) mem3[if3.mem_a[7:2]] <= if3.mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 64; k++) begin
            mem0[k] = 32'h0;
            mem1[k] = 32'h0;
            mem3[k] = 32'h0;
        end
        mem0[0]  = 32'h00500113;
        mem0[1]  = 32'h11111111;
        mem1[0]  = 32'h00500113;
        mem1[1]  = 32'h11111111;
        mem3[2]  = 32'hCAFEF00D;
        mem3[32] = 32'hA5A5A5A5;

        {if0.c0_req, if0.c0_we, if0.c1_req, if0.c1_we} = 4'b0;
        {if1.c0_req, if1.c0_we, if1.c1_req, if1.c1_we} = 4'b0;
        {if3.c0_req, if3.c0_we, if3.c1_req, if3.c1_we} = 4'b0;
        if0.c0_addr = 0; if0.c0_wdata = 0; if0.c1_addr = 0; if0.c1_wdata = 0;
        if1.c0_addr = 0; if1.c0_wdata = 0; if1.c1_addr = 0; if1.c1_wdata = 0;
        if3.c0_addr = 0; if3.c0_wdata = 0; if3.c1_addr = 0; if3.c1_wdata = 0;

        // Reset state, with a request pending to show it is ignored in reset.
        reset = 1'b1;
        if0.c0_req = 1'b1;
        tick();
        tick();
        chk("rst_gnt",    if0.gnt, 2'b00);
        chk("rst_ready",  {if0.c0_ready, if0.c1_ready}, 2'b00);
        chk("rst_mem_we", if0.mem_we, 1'b0);
        chk("rst_mem_a",  if0.mem_a, 32'h0);
        chk("rst_mem_wd", if0.mem_wd, 32'h0);
        chk("rst_rdata",  if0.c0_rdata, 32'h0);
        if0.c0_req = 1'b0;
        reset = 1'b0;
        tick();

        // Single read from port 0: grant next cycle, ready the cycle after.
        if0.c0_req = 1'b1; if0.c0_we = 1'b0; if0.c0_addr = 32'h00;
        tick();
        chk("rd_gnt",      if0.gnt, 2'b01);
        chk("rd_mem_a",    if0.mem_a, 32'h00);
        chk("rd_mem_we",   if0.mem_we, 1'b0);
        chk("rd_early_rdy", if0.c0_ready, 1'b0);
        tick();
        chk("rd_ready",    if0.c0_ready, 1'b1);
        chk("rd_rdata",    if0.c0_rdata, 32'h00500113);
        chk("rd_c1_ready", if0.c1_ready, 1'b0);
        chk("rd_resp_we",  if0.mem_we, 1'b0);
        chk("rd_resp_gnt", if0.gnt, 2'b01);
        if0.c0_req = 1'b0;
        tick();
        chk("rd_idle_rdy", if0.c0_ready, 1'b0);
        chk("rd_idle_gnt", if0.gnt, 2'b00);

        // Port 1 write to 0x40, then port 0 reads it back.
        if0.c1_req = 1'b1; if0.c1_we = 1'b1; if0.c1_addr = 32'h40; if0.c1_wdata = 32'hDEADBEEF;
        tick();
        chk("wr_mem_we", if0.mem_we, 1'b1);
        chk("wr_mem_a",  if0.mem_a, 32'h40);
        chk("wr_mem_wd", if0.mem_wd, 32'hDEADBEEF);
        chk("wr_gnt",    if0.gnt, 2'b10);
        tick();
        chk("wr_resp_we", if0.mem_we, 1'b0);
        chk("wr_ready",   if0.c1_ready, 1'b1);
        chk("wr_c0_rdy",  if0.c0_ready, 1'b0);
        if0.c1_req = 1'b0; if0.c1_we = 1'b0;
        tick();
        chk("wr_mem",      mem0[16], 32'hDEADBEEF);
        chk("wr_idle_we",  if0.mem_we, 1'b0);
        if0.c0_req = 1'b1; if0.c0_addr = 32'h40;
        tick();
        tick();
        chk("rb_ready", if0.c0_ready, 1'b1);
        chk("rb_rdata", if0.c0_rdata, 32'hDEADBEEF);
        if0.c0_req = 1'b0;
        tick();

        // Both ports held high: u0 alternates 0,1,..., u1 always serves port 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        if0.c0_req = 1'b1; if0.c0_addr = 32'h00; if0.c1_req = 1'b1; if0.c1_addr = 32'h04;
        if1.c0_req = 1'b1; if1.c0_addr = 32'h00; if1.c1_req = 1'b1; if1.c1_addr = 32'h04;
        for (int i = 1; i <= 17; i++) begin
            logic rr_port;
            logic rr_resp;
            tick();
            rr_port = ((i / 3) % 2) == 1;
            rr_resp = (i % 3) == 2;
            chk("rr_gnt", if0.gnt, (i % 3 == 0) ? 2'b00 : (rr_port ? 2'b10 : 2'b01));
            chk("rr_c0_ready", if0.c0_ready, rr_resp && !rr_port);
            chk("rr_c1_ready", if0.c1_ready, rr_resp && rr_port);
            if (rr_resp) begin
                chk("rr_rdata", rr_port ? if0.c1_rdata : if0.c0_rdata,
                    rr_port ? 32'h11111111 : 32'h00500113);
            end
            chk("fp_gnt", if1.gnt, (i % 3 == 0) ? 2'b00 : 2'b01);
            chk("fp_c0_ready", if1.c0_ready, rr_resp);
            chk("fp_c1_ready", if1.c1_ready, 1'b0);
        end
        if0.c0_req = 1'b0; if0.c1_req = 1'b0;
        if1.c0_req = 1'b0; if1.c1_req = 1'b0;
        tick();
        tick();

        // Three wait states: address held for four ACCESS cycles, ready at t+5.
        if3.c0_req = 1'b1; if3.c0_we = 1'b0; if3.c0_addr = 32'h08;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("ws_mem_a",  if3.mem_a, 32'h08);
            chk("ws_gnt",    if3.gnt, 2'b01);
            chk("ws_ready",  if3.c0_ready, 1'b0);
            chk("ws_mem_we", if3.mem_we, 1'b0);
        end
        tick();
        chk("ws_ready_t5", if3.c0_ready, 1'b1);
        chk("ws_rdata",    if3.c0_rdata, 32'hCAFEF00D);
        if3.c0_req = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a write to 0x80.
        if3.c1_req = 1'b1; if3.c1_we = 1'b1; if3.c1_addr = 32'h80; if3.c1_wdata = 32'h12345678;
        tick();
        tick();
        chk("mid_pre_gnt", if3.gnt, 2'b10);
        reset = 1'b1;
        if3.c1_req = 1'b0;
        #1;
        chk("mid_gnt",    if3.gnt, 2'b00);
        chk("mid_mem_we", if3.mem_we, 1'b0);
        chk("mid_mem_a",  if3.mem_a, 32'h0);
        chk("mid_mem_wd", if3.mem_wd, 32'h0);
        chk("mid_ready",  if3.c1_ready, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_ready", if3.c1_ready, 1'b0);
        end
        chk("mid_mem_kept", mem3[32], 32'hA5A5A5A5);

        // The next request completes normally.
        if3.c1_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("post_mem_we", if3.mem_we, (i == 4));
        end
        tick();
        chk("post_ready", if3.c1_ready, 1'b1);
        if3.c1_req = 1'b0; if3.c1_we = 1'b0;
        tick();
        chk("post_mem", mem3[32], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single unified instruction/data memory (combinational read, synchronous write) between the multicycle core (port 0) and a host loader/DMA requester (port 1). Each port uses a req/ready handshake. The arbiter grants one transaction at a time, optionally inserts programmable wait states, and registers read data. It sits between the core's adr/writedata/memwrite/readdata bus and the memory.

Parameters:
- DATA_W, 32, data width of both ports and the memory.
- ADDR_W, 32, byte address width.
- WAIT_STATES, 0, extra ACCESS cycles per transaction (0..15).
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- c0_req  in  1  port 0 request
- c0_we  in  1  port 0 write enable (1 = write, 0 = read)
- c0_addr  in  ADDR_W  port 0 byte address
- c0_wdata  in  DATA_W  port 0 write data
- c0_ready  out  1  port 0 transaction complete (1-cycle pulse)
- c0_rdata  out  DATA_W  port 0 read data, valid while c0_ready
- c1_req, c1_we, c1_addr, c1_wdata, c1_ready, c1_rdata  same as port 0, for port 1
- gnt  out  2  one-hot grant, bit i = port i owns the memory
- mem_we  out  1  memory write enable
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data (combinational from mem_a)

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - On reset: state = IDLE; owner = 0; last = 1 (so port 0 wins the first tie); wait counter = 0; rdata register = 0.
  - Outputs during reset: c0_ready = c1_ready = 0, gnt = 00, mem_we = 0, mem_a = 0, mem_wd = 0.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Any req high: latch owner, load cnt = WAIT_STATES, go to ACCESS.
  - ACCESS:
    - mem_a = owner addr; mem_wd = owner wdata.
    - cnt != 0: decrement cnt, stay.
    - cnt == 0: mem_we = owner we for exactly this cycle; rdata register <= mem_rd (captured on reads; on writes, rdata is don't-care but must stay deterministic, i.e. also capture mem_rd); go to RESP.
  - RESP:
    - c<owner>_ready = 1 for one cycle; last <= owner; go to IDLE.
- Outputs outside ACCESS: mem_we = 0, mem_a = 0, mem_wd = 0.
- gnt = one-hot of owner in ACCESS and RESP; 00 in IDLE.
- Both c0_rdata and c1_rdata drive the rdata register. Data is meaningful only with the respective ready.
- Latency: req sampled in IDLE at cycle t -> ready at cycle t + 2 + WAIT_STATES. Throughput is one transaction per 3 + WAIT_STATES cycles.
- Arbitration (sampled only in IDLE):
  - Single requester wins.
  - Both requesting:
    - FIXED_PRIO = 1: port 0 wins.
    - FIXED_PRIO = 0: the port != last wins.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable from assertion until it sees ready.
  - Arbiter samples addr/we/wdata combinationally from the owner throughout ACCESS.
  - req still high in the IDLE cycle after ready is treated as a new back-to-back transaction.
  - Dropping req before ready is a protocol violation; the arbiter still completes the transaction and pulses ready.
- A non-owner's req is ignored until the next IDLE; no ready is issued to it.
- Reset mid-transaction: immediate return to IDLE. The in-flight write is not performed if reset asserts before the ACCESS cnt == 0 clock edge. No ready pulse is issued.
- Addresses are passed through unmodified; word alignment is the memory's concern.

Test Plan:
- WAIT_STATES = 0, c0 read addr 0x00 (memory holds 0x00500113) -> gnt = 01 at t+1, mem_we never high, c0_ready pulse at t+2, c0_rdata = 0x00500113.
- c1 write addr 0x40, wdata 0xDEADBEEF, then c0 read 0x40 -> mem_we high exactly one cycle with mem_a = 0x40; c0_rdata = 0xDEADBEEF.
- FIXED_PRIO = 0, c0_req and c1_req held high for 6 transactions -> grant order 0,1,0,1,0,1; each ready exactly 3 cycles apart.
- FIXED_PRIO = 1, both held high -> port 0 granted every time; c1_ready never pulses.
- WAIT_STATES = 3, c0 read -> ready at t+5; mem_a stable at the owner address for all 4 ACCESS cycles.
- Assert reset during the 2nd ACCESS cycle of a WAIT_STATES = 3 write to 0x80 -> outputs are zero immediately, memory[0x80] unchanged, no ready pulse; the next request completes normally.
